guess_grader: RTL and testbench
===============================

Name: guess_grader

Overview:
Scoring stage directly downstream of the master-code loader. Takes the four stored master shapes and a four-slot player guess, and counts exact matches (zood: right shape, right slot). It also counts shape-only matches (znarly: right shape, wrong slot). A multi-cycle FSM performs the comparison, and the block tracks round count and win/loss. It drives gamePlaying and resetMaster back to the loader.

Parameters:
MAX_ROUNDS, 10, number of graded guesses allowed before loss (1..15)
SHAPES, 6, highest legal shape code; legal shapes are 1..SHAPES, 0 = empty

Ports:
CLOCK_50  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low; reset==0 at a posedge clears all state
master0..master3  input  3 each  stored master shapes, slot 0..3
masterLoaded  input  1  all four master slots nonzero
guess0..guess3  input  3 each  player guess, slot 0..3
gradeIt  input  1  level request; internally rising-edge detected
newGame  input  1  level request; internally rising-edge detected
zood  output  3  exact-match count of last graded guess, 0..4
znarly  output  3  shape-only match count of last graded guess, 0..4
gradeDone  output  1  one-cycle pulse when zood/znarly update
busy  output  1  high while FSM not in IDLE
roundNum  output  4  guesses graded this game
won  output  1  sticky: last grade had zood==4
lost  output  1  sticky: roundNum==MAX_ROUNDS and not won
gamePlaying  output  1  masterLoaded & ~won & ~lost
resetMaster  output  1  one-cycle pulse on accepted newGame

Behaviour:
- Reset (reset==0 at an edge): FSM=IDLE; all outputs 0; edge-detect history regs 0. Reset mid-grade aborts with no gradeDone.
- Edge detect: prevGrade <= gradeIt each cycle. gradeRise = gradeIt & ~prevGrade. newRise is derived the same way.
- Accept condition: gradeRise & IDLE & masterLoaded & ~won & ~lost. Otherwise the rise is dropped, with no queueing.
- FSM states IDLE, ZOOD, COUNT, DONE.
  - E0, accepting edge: latch guess0..3 into gq[0..3]; clear acc regs; idx<=0; go to ZOOD.
  - ZOOD, edges E1..E4: for idx 0..3, zAcc += (gq[idx]==master_idx) & (gq[idx]!=0). At idx==3 go to COUNT with s<=1.
  - COUNT, edges E5..E10: for s=1..SHAPES, cm = #slots with master==s and cg = #slots with gq==s (combinational, 0..4). mAcc += min(cm,cg). At s==SHAPES go to DONE.
  - DONE, edge E11: zood<=zAcc; znarly<=mAcc-zAcc; roundNum+=1; won<=(zAcc==4); lost<=(zAcc!=4)&(roundNum+1==MAX_ROUNDS). Go to IDLE.
  - gradeDone is high for exactly the cycle after E11. busy is high from after E0 through the cycle after E11 exclusive, i.e. busy is already low when gradeDone is high.
- Latency: 11 clocks from accepting edge to output update, fixed for SHAPES=6.
- Guess inputs may change after E0 without effect; master inputs must be stable while busy.
- Guess slot value 0 never matches: excluded in ZOOD, and the COUNT loop never visits 0. The round is still counted.
- Width rules: zAcc, mAcc are 3 bits. mAcc>=zAcc always holds, so the subtraction never underflows. roundNum saturates, because lost blocks further grades.
- Win on final round: won=1, lost=0.
- newRise at any state, including busy: FSM->IDLE, zood/znarly/roundNum/won/lost cleared, no gradeDone. resetMaster pulses for the cycle after that edge.
- newRise on the same edge as gradeRise: newGame wins, and the grade is dropped.
- gamePlaying is combinational from registered won/lost and the masterLoaded input.

Test Plan:
- Master {1,2,3,4}, guess {1,2,3,4}, pulse gradeIt -> gradeDone 11 clocks after the accepting edge; zood=4, znarly=0, won=1, gamePlaying=0, roundNum=1.
- Master {1,2,3,4}, guess {4,3,2,1} -> zood=0, znarly=4, won=0.
- Master {1,1,2,2}, guess {1,2,1,5} -> zood=1, znarly=2. Also master {3,3,3,3}, guess {3,0,0,3} -> zood=2, znarly=0.
- MAX_ROUNDS=2 with two non-winning grades -> lost=1 after the second gradeDone; a third gradeIt is ignored (no busy, roundNum stays 2).
- gradeIt held high for 20 cycles -> exactly one grade. gradeIt while busy or with masterLoaded=0 -> ignored.
- newGame at E6 mid-grade -> no gradeDone; resetMaster is a one-cycle pulse; all counts 0. Reset low mid-grade -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/guess_grader.sv
// guess_grader -- scores a four-slot player guess against the stored master code.
//
// Counts exact matches (zood: right shape, right slot) and shape-only matches
// (znarly: right shape, wrong slot) with a multi-cycle FSM. It also tracks the
// round count and the sticky win/loss state, and drives gamePlaying and
// resetMaster back to the master-code loader.
//
// Ports:
//   CLOCK_50          system clock, everything on posedge
//   reset             synchronous, active-low
//   master0..master3  stored master shapes (must be stable while busy)
//   masterLoaded      all four master slots hold a shape
//   guess0..guess3    player guess, latched on the accepting edge
//   gradeIt, newGame  level requests, rising-edge detected internally
//   zood, znarly      exact / shape-only counts of the last graded guess
//   gradeDone         one-cycle pulse when zood/znarly update
//   busy              FSM not idle
//   roundNum          guesses graded this game
//   won, lost         sticky game result
//   gamePlaying       masterLoaded & ~won & ~lost
//   resetMaster       one-cycle pulse after an accepted newGame
module guess_grader #(
  parameter int MAX_ROUNDS = 10,
  parameter int SHAPES     = 6
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] master0,
  input  logic [2:0] master1,
  input  logic [2:0] master2,
  input  logic [2:0] master3,
  input  logic       masterLoaded,
  input  logic [2:0] guess0,
  input  logic [2:0] guess1,
  input  logic [2:0] guess2,
  input  logic [2:0] guess3,
  input  logic       gradeIt,
  input  logic       newGame,
  output logic [2:0] zood,
  output logic [2:0] znarly,
  output logic       gradeDone,
  output logic       busy,
  output logic [3:0] roundNum,
  output logic       won,
  output logic       lost,
  output logic       gamePlaying,
  output logic       resetMaster
);

  localparam logic [3:0] MAX_R   = 4'(MAX_ROUNDS);
  localparam logic [2:0] LAST_SH = 3'(SHAPES);

  typedef enum logic [1:0] {IDLE, ZOOD, COUNT, DONE} state_t;

  state_t     state_q, state_d;
  logic       prev_grade_q, prev_grade_d;
  logic       prev_new_q, prev_new_d;
  logic [2:0] gq_q [4];
  logic [2:0] gq_d [4];
  logic [1:0] idx_q, idx_d;
  logic [2:0] s_q, s_d;
  logic [2:0] z_acc_q, z_acc_d;
  logic [2:0] m_acc_q, m_acc_d;
  logic [2:0] zood_q, zood_d;
  logic [2:0] znarly_q, znarly_d;
  logic [3:0] round_q, round_d;
  logic       won_q, won_d;
  logic       lost_q, lost_d;
  logic       grade_done_q, grade_done_d;
  logic       reset_master_q, reset_master_d;

  logic [2:0] master_w [4];
  logic [2:0] guess_w [4];
  logic       grade_rise, new_rise;
  logic       z_hit;
  logic [2:0] cm, cg, cmin;

  assign master_w[0] = master0;
  assign master_w[1] = master1;
  assign master_w[2] = master2;
  assign master_w[3] = master3;
  assign guess_w[0]  = guess0;
  assign guess_w[1]  = guess1;
  assign guess_w[2]  = guess2;
  assign guess_w[3]  = guess3;

  assign grade_rise = gradeIt & ~prev_grade_q;
  assign new_rise   = newGame & ~prev_new_q;

  // Empty guess slots (0) never count as an exact match.
  assign z_hit = (gq_q[idx_q] == master_w[idx_q]) && (gq_q[idx_q] != 3'd0);

  // Per-shape occurrence counts for the shape currently visited by COUNT.
  // Summing min(cm, cg) over all shapes gives the total common shapes,
  // exact matches included; znarly is that total minus zood.
  always_comb begin
    cm = '0;
    cg = '0;
    for (int i = 0; i < 4; i++) begin
      cm = cm + 3'(master_w[i] == s_q);
      cg = cg + 3'(gq_q[i] == s_q);
    end
    cmin = (cm < cg) ? cm : cg;
  end

  always_comb begin
    state_d        = state_q;
    prev_grade_d   = gradeIt;
    prev_new_d     = newGame;
    gq_d           = gq_q;
    idx_d          = idx_q;
    s_d            = s_q;
    z_acc_d        = z_acc_q;
    m_acc_d        = m_acc_q;
    zood_d         = zood_q;
    znarly_d       = znarly_q;
    round_d        = round_q;
    won_d          = won_q;
    lost_d         = lost_q;
    grade_done_d   = 1'b0;
    reset_master_d = 1'b0;

    if (new_rise) begin
      // newGame overrides everything, including a grade in flight or a
      // simultaneous gradeIt rise.
      state_d        = IDLE;
      zood_d         = '0;
      znarly_d       = '0;
      round_d        = '0;
      won_d          = 1'b0;
      lost_d         = 1'b0;
      reset_master_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (grade_rise && masterLoaded && !won_q && !lost_q) begin
            gq_d    = guess_w;
            z_acc_d = '0;
            m_acc_d = '0;
            idx_d   = '0;
            state_d = ZOOD;
          end
        end
        ZOOD: begin
          z_acc_d = z_acc_q + 3'(z_hit);
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            s_d     = 3'd1;
            state_d = COUNT;
          end
        end
        COUNT: begin
          m_acc_d = m_acc_q + cmin;
          s_d     = s_q + 3'd1;
          if (s_q == LAST_SH) begin
            state_d = DONE;
          end
        end
        DONE: begin
          zood_d       = z_acc_q;
          znarly_d     = m_acc_q - z_acc_q;
          round_d      = round_q + 4'd1;
          won_d        = (z_acc_q == 3'd4);
          // A win on the last allowed round is a win, not a loss.
          lost_d       = (z_acc_q != 3'd4) && ((round_q + 4'd1) == MAX_R);
          grade_done_d = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q        <= IDLE;
      prev_grade_q   <= 1'b0;
      prev_new_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        gq_q[i] <= '0;
      end
      idx_q          <= '0;
      s_q            <= '0;
      z_acc_q        <= '0;
      m_acc_q        <= '0;
      zood_q         <= '0;
      znarly_q       <= '0;
      round_q        <= '0;
      won_q          <= 1'b0;
      lost_q         <= 1'b0;
      grade_done_q   <= 1'b0;
      reset_master_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_grade_q   <= prev_grade_d;
      prev_new_q     <= prev_new_d;
      gq_q           <= gq_d;
      idx_q          <= idx_d;
      s_q            <= s_d;
      z_acc_q        <= z_acc_d;
      m_acc_q        <= m_acc_d;
      zood_q         <= zood_d;
      znarly_q       <= znarly_d;
      round_q        <= round_d;
      won_q          <= won_d;
      lost_q         <= lost_d;
      grade_done_q   <= grade_done_d;
      reset_master_q <= reset_master_d;
    end
  end

  assign zood        = zood_q;
  assign znarly      = znarly_q;
  assign gradeDone   = grade_done_q;
  assign busy        = (state_q != IDLE);
  assign roundNum    = round_q;
  assign won         = won_q;
  assign lost        = lost_q;
  assign gamePlaying = masterLoaded & ~won_q & ~lost_q;
  assign resetMaster = reset_master_q;

endmodule

// File: tb/tb_guess_grader.sv
// Directed testbench for guess_grader, built with MAX_ROUNDS=2 so the loss
// and last-round-win boundaries are reachable in a couple of grades.
module tb_guess_grader;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [2:0] m0, m1, m2, m3;
  logic       masterLoaded;
  logic [2:0] g0, g1, g2, g3;
  logic       gradeIt, newGame;
  logic [2:0] zood, znarly;
  logic       gradeDone, busy;
  logic [3:0] roundNum;
  logic       won, lost, gamePlaying, resetMaster;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  guess_grader #(.MAX_ROUNDS(2), .SHAPES(6)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .master0(m0), .master1(m1), .master2(m2), .master3(m3),
    .masterLoaded(masterLoaded),
    .guess0(g0), .guess1(g1), .guess2(g2), .guess3(g3),
    .gradeIt(gradeIt), .newGame(newGame),
    .zood(zood), .znarly(znarly), .gradeDone(gradeDone), .busy(busy),
    .roundNum(roundNum), .won(won), .lost(lost),
    .gamePlaying(gamePlaying), .resetMaster(resetMaster)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_master(input logic [2:0] a, b, c, d);
    m0 = a; m1 = b; m2 = c; m3 = d;
  endtask

  // Pulse newGame for one cycle and check the resetMaster pulse shape.
  task automatic do_new_game();
    newGame = 1'b1;
    tick();
    checks++; if (resetMaster !== 1'b1) begin errors++; $display("FAIL newgame_pulse: resetMaster=%b expected 1", resetMaster); end
    newGame = 1'b0;
    tick();
    checks++; if (resetMaster !== 1'b0) begin errors++; $display("FAIL newgame_pulse_end: resetMaster=%b expected 0", resetMaster); end
  endtask

  // Returns just after the accepting edge E0.
  task automatic start_grade(input logic [2:0] a, b, c, d);
    g0 = a; g1 = b; g2 = c; g3 = d;
    gradeIt = 1'b1;
    tick();
    gradeIt = 1'b0;
  endtask

  // Edges from E0 until gradeDone is seen; -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (gradeDone === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if ({zood, znarly, gradeDone, busy, roundNum, won, lost, gamePlaying, resetMaster} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: zood=%0d znarly=%0d done=%b busy=%b round=%0d won=%b lost=%b play=%b rm=%b expected all 0",
        zood, znarly, gradeDone, busy, roundNum, won, lost, gamePlaying, resetMaster); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_win();
    int n;
    set_master(1, 2, 3, 4); masterLoaded = 1'b1;
    do_new_game();
    checks++; if (gamePlaying !== 1'b1) begin errors++; $display("FAIL win_playing_before: gamePlaying=%b expected 1", gamePlaying); end
    start_grade(1, 2, 3, 4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL win_busy: busy=%b expected 1", busy); end
    wait_done(n);
    checks++; if (n != 11) begin errors++; $display("FAIL win_latency: latency=%0d expected 11", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL win_busy_at_done: busy=%b expected 0", busy); end
    checks++; if (zood !== 3'd4 || znarly !== 3'd0) begin errors++; $display("FAIL win_counts: zood=%0d znarly=%0d expected 4 0", zood, znarly); end
    checks++; if (won !== 1'b1 || lost !== 1'b0 || gamePlaying !== 1'b0 || roundNum !== 4'd1) begin
      errors++; $display("FAIL win_state: won=%b lost=%b play=%b round=%0d expected 1 0 0 1", won, lost, gamePlaying, roundNum); end
    tick();
    checks++; if (gradeDone !== 1'b0) begin errors++; $display("FAIL win_done_pulse: gradeDone=%b expected 0", gradeDone); end
    $display("test_win: zood=%0d znarly=%0d latency=%0d", zood, znarly, n);
  endtask

  task automatic test_patterns();
    int n;
    do_new_game();
    start_grade(4, 3, 2, 1); wait_done(n);
    checks++; if (n != 11 || zood !== 3'd0 || znarly !== 3'd4 || won !== 1'b0) begin
      errors++; $display("FAIL pat_reverse: lat=%0d zood=%0d znarly=%0d won=%b expected 11 0 4 0", n, zood, znarly, won); end
    $display("test_patterns: master 1234 guess 4321 -> zood=%0d znarly=%0d", zood, znarly);

    set_master(1, 1, 2, 2);
    do_new_game();
    start_grade(1, 2, 1, 5); wait_done(n);
    checks++; if (n != 11 || zood !== 3'd1 || znarly !== 3'd2) begin
      errors++; $display("FAIL pat_dup: lat=%0d zood=%0d znarly=%0d expected 11 1 2", n, zood, znarly); end
    $display("test_patterns: master 1122 guess 1215 -> zood=%0d znarly=%0d", zood, znarly);

    set_master(3, 3, 3, 3);
    do_new_game();
    start_grade(3, 0, 0, 3); wait_done(n);
    checks++; if (n != 11 || zood !== 3'd2 || znarly !== 3'd0 || roundNum !== 4'd1) begin
      errors++; $display("FAIL pat_empty: lat=%0d zood=%0d znarly=%0d round=%0d expected 11 2 0 1", n, zood, znarly, roundNum); end
    $display("test_patterns: master 3333 guess 3003 -> zood=%0d znarly=%0d", zood, znarly);
  endtask

  task automatic test_lost();
    int n;
    int busy_cnt;
    set_master(1, 2, 3, 4);
    do_new_game();
    start_grade(4, 3, 2, 1); wait_done(n);
    checks++; if (roundNum !== 4'd1 || lost !== 1'b0 || gamePlaying !== 1'b1) begin
      errors++; $display("FAIL lost_round1: round=%0d lost=%b play=%b expected 1 0 1", roundNum, lost, gamePlaying); end
    start_grade(5, 5, 5, 5); wait_done(n);
    checks++; if (n != 11 || roundNum !== 4'd2 || lost !== 1'b1 || won !== 1'b0 || gamePlaying !== 1'b0) begin
      errors++; $display("FAIL lost_round2: lat=%0d round=%0d lost=%b won=%b play=%b expected 11 2 1 0 0", n, roundNum, lost, won, gamePlaying); end
    checks++; if (zood !== 3'd0 || znarly !== 3'd0) begin errors++; $display("FAIL lost_counts: zood=%0d znarly=%0d expected 0 0", zood, znarly); end
    busy_cnt = 0;
    start_grade(1, 2, 3, 4);
    for (int i = 0; i < 15; i++) begin
      if (busy === 1'b1 || gradeDone === 1'b1) busy_cnt++;
      tick();
    end
    checks++; if (busy_cnt != 0 || roundNum !== 4'd2 || won !== 1'b0) begin
      errors++; $display("FAIL lost_blocks: active_cycles=%0d round=%0d won=%b expected 0 2 0", busy_cnt, roundNum, won); end
    $display("test_lost: round=%0d lost=%b", roundNum, lost);

    // Win on the final allowed round: won, not lost.
    do_new_game();
    start_grade(4, 3, 2, 1); wait_done(n);
    start_grade(1, 2, 3, 4); wait_done(n);
    checks++; if (won !== 1'b1 || lost !== 1'b0 || roundNum !== 4'd2) begin
      errors++; $display("FAIL last_round_win: won=%b lost=%b round=%0d expected 1 0 2", won, lost, roundNum); end
    $display("test_lost: last-round win won=%b lost=%b", won, lost);
  endtask

  task automatic test_hold_and_ignore();
    int done_cnt;
    int busy_cnt;
    set_master(1, 2, 3, 4);
    do_new_game();
    // gradeIt held high for 20 cycles -> one grade only.
    g0 = 4; g1 = 3; g2 = 2; g3 = 1;
    gradeIt = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 19) gradeIt = 1'b0;
      if (gradeDone === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1 || roundNum !== 4'd1) begin
      errors++; $display("FAIL hold_one_grade: grades=%0d round=%0d expected 1 1", done_cnt, roundNum); end
    $display("test_hold: grades=%0d", done_cnt);

    // A new rise while busy is dropped.
    do_new_game();
    start_grade(4, 3, 2, 1);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) gradeIt = 1'b1;
      if (i == 3) gradeIt = 1'b0;
      tick();
      if (gradeDone === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1 || roundNum !== 4'd1) begin
      errors++; $display("FAIL busy_ignore: grades=%0d round=%0d expected 1 1", done_cnt, roundNum); end
    $display("test_busy_ignore: grades=%0d", done_cnt);

    // masterLoaded low -> request dropped.
    do_new_game();
    masterLoaded = 1'b0;
    start_grade(1, 2, 3, 4);
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy === 1'b1 || gradeDone === 1'b1) busy_cnt++;
      tick();
    end
    checks++; if (busy_cnt != 0 || roundNum !== 4'd0 || gamePlaying !== 1'b0) begin
      errors++; $display("FAIL unloaded_ignore: active_cycles=%0d round=%0d play=%b expected 0 0 0", busy_cnt, roundNum, gamePlaying); end
    masterLoaded = 1'b1;
    $display("test_unloaded_ignore: active_cycles=%0d", busy_cnt);
  endtask

  task automatic test_abort();
    int n;
    int done_cnt;
    set_master(1, 2, 3, 4);
    do_new_game();
    start_grade(4, 3, 2, 1); wait_done(n);
    // newGame arrives at E6 of the second grade.
    start_grade(1, 2, 5, 5);
    repeat (5) tick();
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    checks++; if (resetMaster !== 1'b1 || busy !== 1'b0 || zood !== 3'd0 || znarly !== 3'd0 || roundNum !== 4'd0) begin
      errors++; $display("FAIL newgame_mid: rm=%b busy=%b zood=%0d znarly=%0d round=%0d expected 1 0 0 0 0", resetMaster, busy, zood, znarly, roundNum); end
    tick();
    checks++; if (resetMaster !== 1'b0) begin errors++; $display("FAIL newgame_mid_pulse: resetMaster=%b expected 0", resetMaster); end
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (gradeDone === 1'b1) done_cnt++;
      tick();
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL newgame_mid_nodone: grades=%0d expected 0", done_cnt); end
    $display("test_newgame_mid: round=%0d", roundNum);

    // newGame and gradeIt rise on the same edge: newGame wins.
    gradeIt = 1'b1; newGame = 1'b1;
    tick();
    gradeIt = 1'b0; newGame = 1'b0;
    checks++; if (busy !== 1'b0 || resetMaster !== 1'b1) begin
      errors++; $display("FAIL same_edge: busy=%b rm=%b expected 0 1", busy, resetMaster); end
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (gradeDone === 1'b1 || busy === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL same_edge_nograde: active_cycles=%0d expected 0", done_cnt); end
    $display("test_same_edge: busy=%b", busy);

    // Reset pulled low mid-grade.
    start_grade(4, 3, 2, 1); wait_done(n);
    start_grade(1, 2, 3, 4);
    repeat (4) tick();
    reset = 1'b0;
    tick();
    checks++; if ({zood, znarly, gradeDone, busy, roundNum, won, lost, resetMaster} !== 15'h0) begin
      errors++; $display("FAIL reset_mid: zood=%0d znarly=%0d done=%b busy=%b round=%0d won=%b lost=%b rm=%b expected all 0",
        zood, znarly, gradeDone, busy, roundNum, won, lost, resetMaster); end
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (gradeDone === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL reset_mid_nodone: grades=%0d expected 0", done_cnt); end
    $display("test_reset_mid: round=%0d", roundNum);
  endtask

  initial begin
    reset = 1'b0; masterLoaded = 1'b0; gradeIt = 1'b0; newGame = 1'b0;
    m0 = 0; m1 = 0; m2 = 0; m3 = 0;
    g0 = 0; g1 = 0; g2 = 0; g3 = 0;
    test_reset();
    test_win();
    test_patterns();
    test_lost();
    test_hold_and_ignore();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
